axi_lite_ptgen_master: RTL and testbench

Parametrised AXI4-Lite master pattern generator and checker, the next generation of the single-shot M00_AXI test master. A rising edge on INIT_AXI_TXN starts a burst of NUM_TXN single-beat writes of a deterministic pattern and/or read-back-and-compare transactions, depending on MODE. It reports completion, a sticky error flag, a saturating mismatch counter and the failing address. It sits between the block-design wrapper's init/done/error pins and an AXI VIP slave or user register slave.

---
 rtl/axi_lite_ptgen_master.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_lite_ptgen_master.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite master that writes a counting pattern and/or reads it back and
// compares, reporting done, a sticky error, a mismatch count and first bad address.
module axi_lite_ptgen_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_TXN    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter logic [31:0] SEED       = 32'hAA00_0000,
    parameter int unsigned MODE       = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      INIT_AXI_TXN,
    output logic                      TXN_DONE,
    output logic                      ERROR,
    output logic [15:0]               ERR_CNT,
    output logic [ADDR_WIDTH-1:0]     ERR_ADDR,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WVALID,
    input  logic                      WREADY,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RVALID,
    output logic                      RREADY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WISSUE,
        S_WADDR,
        S_WRESP,
        S_RISSUE,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    localparam logic [8:0]            LAST = 9'(NUM_TXN - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] PAT0 = DATA_WIDTH'(SEED);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_init_q;
    logic [8:0]              r_idx;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_pat;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_error;
    logic [15:0]             r_err_cnt;
    logic [ADDR_WIDTH-1:0]   r_err_addr;

    logic w_start;
    logic w_accept;
    logic w_awvalid;
    logic w_wvalid;
    logic w_bready;
    logic w_arvalid;
    logic w_rready;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_ok;
    logic w_w_ok;
    logic w_last;
    logic w_beat_err;

    assign w_start  = INIT_AXI_TXN & ~r_init_q;
    assign w_accept = w_start & ((r_state == S_IDLE) | (r_state == S_DONE));

    // VALID/READY outputs decode registered state only
    assign w_awvalid = (r_state == S_WADDR) & ~r_aw_done;
    assign w_wvalid  = (r_state == S_WADDR) & ~r_w_done;
    assign w_bready  = (r_state == S_WRESP);
    assign w_arvalid = (r_state == S_RADDR);
    assign w_rready  = (r_state == S_RDATA);

    assign w_aw_hs = w_awvalid & AWREADY;
    assign w_w_hs  = w_wvalid & WREADY;
    assign w_b_hs  = w_bready & BVALID;
    assign w_ar_hs = w_arvalid & ARREADY;
    assign w_r_hs  = w_rready & RVALID;

    assign w_aw_ok = r_aw_done | w_aw_hs;
    assign w_w_ok  = r_w_done | w_w_hs;
    assign w_last  = (r_idx == LAST);

    assign w_beat_err = (w_b_hs & (BRESP != 2'b00))
                      | (w_r_hs & ((RRESP != 2'b00) | (RDATA != r_pat)));

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_next = (MODE == 2) ? S_RISSUE : S_WISSUE;
                end
            end
            S_WISSUE: w_next = S_WADDR;
            S_WADDR: begin
                if (w_aw_ok & w_w_ok) begin
                    w_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (w_b_hs) begin
                    if (!w_last) begin
                        w_next = S_WISSUE;
                    end else if (MODE == 1) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RISSUE;
                    end
                end
            end
            S_RISSUE: w_next = S_RADDR;
            S_RADDR: begin
                if (w_ar_hs) begin
                    w_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (w_r_hs) begin
                    w_next = w_last ? S_DONE : S_RADDR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_init_q   <= 1'b0;
            r_idx      <= 9'd0;
            r_addr     <= '0;
            r_pat      <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_error    <= 1'b0;
            r_err_cnt  <= 16'd0;
            r_err_addr <= '0;
        end else begin
            r_init_q <= INIT_AXI_TXN;
            if (w_accept) begin
                r_idx      <= 9'd0;
                r_addr     <= BASE;
                r_pat      <= PAT0;
                r_error    <= 1'b0;
                r_err_cnt  <= 16'd0;
                r_err_addr <= '0;
            end else if (w_b_hs | w_r_hs) begin
                // the last beat rewinds so a write phase hands over to reads at index 0
                if (w_last) begin
                    r_idx  <= 9'd0;
                    r_addr <= BASE;
                    r_pat  <= PAT0;
                end else begin
                    r_idx  <= r_idx + 9'd1;
                    r_addr <= r_addr + STEP;
                    r_pat  <= r_pat + DATA_WIDTH'(1);
                end
                if (w_beat_err) begin
                    r_error <= 1'b1;
                    if (r_err_cnt != 16'hFFFF) begin
                        r_err_cnt <= r_err_cnt + 16'd1;
                    end
                    if (!r_error) begin
                        r_err_addr <= r_addr;
                    end
                end
            end
            if (r_state == S_WISSUE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    assign TXN_DONE = (r_state == S_DONE);
    assign ERROR    = r_error;
    assign ERR_CNT  = r_err_cnt;
    assign ERR_ADDR = r_err_addr;

    assign AWADDR  = r_addr;
    assign AWPROT  = 3'b000;
    assign AWVALID = w_awvalid;
    assign WDATA   = r_pat;
    assign WSTRB   = '1;
    assign WVALID  = w_wvalid;
    assign BREADY  = w_bready;
    assign ARADDR  = r_addr;
    assign ARPROT  = 3'b000;
    assign ARVALID = w_arvalid;
    assign RREADY  = w_rready;

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Bench for axi_lite_ptgen_master: behavioural slave with optional stalls and
// fault injection, a table of directed runs and hand-written corner sequences.
module tb_axi_lite_ptgen_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init1 = 1'b0;
    logic init2 = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 1: defaults (MODE 0, 32-bit, 4 transactions)
    logic        done1, error1;
    logic [15:0] errcnt1;
    logic [31:0] erraddr1, awaddr1, wdata1, araddr1;
    logic [2:0]  awprot1, arprot1;
    logic [3:0]  wstrb1;
    logic        awvalid1, wvalid1, bready1, arvalid1, rready1;
    logic        awready1 = 0, wready1 = 0, bvalid1 = 0, arready1 = 0, rvalid1 = 0;
    logic [1:0]  bresp1 = 0, rresp1 = 0;
    logic [31:0] rdata1 = 0;

    axi_lite_ptgen_master u_dut1 (
        .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init1),
        .TXN_DONE(done1), .ERROR(error1), .ERR_CNT(errcnt1), .ERR_ADDR(erraddr1),
        .AWADDR(awaddr1), .AWPROT(awprot1), .AWVALID(awvalid1), .AWREADY(awready1),
        .WDATA(wdata1), .WSTRB(wstrb1), .WVALID(wvalid1), .WREADY(wready1),
        .BRESP(bresp1), .BVALID(bvalid1), .BREADY(bready1),
        .ARADDR(araddr1), .ARPROT(arprot1), .ARVALID(arvalid1), .ARREADY(arready1),
        .RDATA(rdata1), .RRESP(rresp1), .RVALID(rvalid1), .RREADY(rready1)
    );

    // DUT 2: write-only, 64-bit, 8 transactions
    logic        done2, error2;
    logic [15:0] errcnt2;
    logic [31:0] erraddr2, awaddr2, araddr2;
    logic [63:0] wdata2;
    logic [2:0]  awprot2, arprot2;
    logic [7:0]  wstrb2;
    logic        awvalid2, wvalid2, bready2, arvalid2, rready2;
    logic        awready2 = 0, wready2 = 0, bvalid2 = 0, arready2 = 0, rvalid2 = 0;
    logic [1:0]  bresp2 = 0, rresp2 = 0;
    logic [63:0] rdata2 = 0;

    axi_lite_ptgen_master #(
        .DATA_WIDTH(64), .NUM_TXN(8), .MODE(1)
    ) u_dut2 (
        .ACLK(clk), .ARESET(rst), .INIT_AXI_TXN(init2),
        .TXN_DONE(done2), .ERROR(error2), .ERR_CNT(errcnt2), .ERR_ADDR(erraddr2),
        .AWADDR(awaddr2), .AWPROT(awprot2), .AWVALID(awvalid2), .AWREADY(awready2),
        .WDATA(wdata2), .WSTRB(wstrb2), .WVALID(wvalid2), .WREADY(wready2),
        .BRESP(bresp2), .BVALID(bvalid2), .BREADY(bready2),
        .ARADDR(araddr2), .ARPROT(arprot2), .ARVALID(arvalid2), .ARREADY(arready2),
        .RDATA(rdata2), .RRESP(rresp2), .RVALID(rvalid2), .RREADY(rready2)
    );

    // slave configuration, written only by the stimulus process
    bit       cfg_stall = 0;
    bit       cfg_bresp = 0;
    bit [3:0] cfg_corrupt = 0;
    bit [3:0] cfg_rresp = 0;
    int       gen = 0;

    // slave 1 state and logs, written only by the slave 1 process
    int          s_gen = 0;
    int          n_aw = 0, n_w = 0, n_ar = 0, viol = 0, rbeat = 0;
    logic [31:0] aw_log [16];
    logic [31:0] w_log [16];
    logic [31:0] ar_log [16];
    int          aw_cyc [16];
    int          ar_cyc [16];
    logic [31:0] mem [16];
    logic        p_awv = 0, p_wv = 0, p_arv = 0, p_bready = 0, p_rready = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0, off;
    bit          got_aw = 0, got_w = 0, b_pend = 0, rd_pend = 0;
    int          bdly = 0, rdly = 0;

    always @(negedge clk) begin : slave1
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        if (rst || gen != s_gen) begin
            s_gen = gen;
            awready1 = 0; wready1 = 0; arready1 = 0;
            bvalid1 = 0; rvalid1 = 0; bresp1 = 0; rresp1 = 0;
            got_aw = 0; got_w = 0; b_pend = 0; rd_pend = 0; rbeat = 0;
            n_aw = 0; n_w = 0; n_ar = 0; viol = 0;
            p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        end else begin
            aw_hs = p_awv && awready1;
            w_hs  = p_wv && wready1;
            b_hs  = bvalid1 && p_bready;
            ar_hs = p_arv && arready1;
            r_hs  = rvalid1 && p_rready;
            if (p_awv && !aw_hs && (!awvalid1 || awaddr1 != p_awaddr)) viol++;
            if (p_wv && !w_hs && (!wvalid1 || wdata1 != p_wdata)) viol++;
            if (p_arv && !ar_hs && (!arvalid1 || araddr1 != p_araddr)) viol++;
            if (p_bready && !b_hs && !bready1) viol++;
            if (p_rready && !r_hs && !rready1) viol++;
            if (aw_hs && n_aw < 16) begin
                aw_log[n_aw] = p_awaddr; aw_cyc[n_aw] = cyc; n_aw++;
                got_aw = 1; s_awaddr = p_awaddr;
            end
            if (w_hs && n_w < 16) begin
                w_log[n_w] = p_wdata; n_w++;
                got_w = 1; s_wdata = p_wdata;
            end
            if (b_hs) bvalid1 = 0;
            if (got_aw && got_w && !b_pend && !bvalid1) begin
                off = (s_awaddr - 32'h4000_0000) >> 2;
                mem[off[3:0]] = s_wdata;
                got_aw = 0; got_w = 0; b_pend = 1;
                bdly = cfg_stall ? int'($urandom_range(0, 7)) : 0;
            end
            if (b_pend) begin
                if (bdly == 0) begin
                    bvalid1 = 1; bresp1 = cfg_bresp ? 2'b10 : 2'b00; b_pend = 0;
                end else bdly--;
            end
            if (r_hs) begin rvalid1 = 0; rbeat++; end
            if (ar_hs && n_ar < 16) begin
                ar_log[n_ar] = p_araddr; ar_cyc[n_ar] = cyc; n_ar++;
                s_araddr = p_araddr; rd_pend = 1;
                rdly = cfg_stall ? int'($urandom_range(0, 7)) : 0;
            end
            if (rd_pend) begin
                if (rdly == 0) begin
                    off = (s_araddr - 32'h4000_0000) >> 2;
                    rdata1 = mem[off[3:0]];
                    if (rbeat < 4 && cfg_corrupt[rbeat]) rdata1 = rdata1 ^ 32'h0000_0100;
                    rresp1 = (rbeat < 4 && cfg_rresp[rbeat]) ? 2'b10 : 2'b00;
                    rvalid1 = 1; rd_pend = 0;
                end else rdly--;
            end
            awready1 = cfg_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            wready1  = cfg_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            arready1 = cfg_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
        p_awv = awvalid1; p_wv = wvalid1; p_arv = arvalid1;
        p_bready = bready1; p_rready = rready1;
        p_awaddr = awaddr1; p_wdata = wdata1; p_araddr = araddr1;
    end

    // slave 2: always ready, SLVERR on every write, never serves reads
    int          s2_gen = 0, n_aw2 = 0, n_w2 = 0;
    bit          saw_ar2 = 0, got_aw2 = 0, got_w2 = 0;
    logic [31:0] aw2_log [16];
    logic [63:0] w2_log [16];
    logic        p2_awv = 0, p2_wv = 0, p2_bready = 0;
    logic [31:0] p2_awaddr = 0;
    logic [63:0] p2_wdata = 0;

    always @(negedge clk) begin : slave2
        arready2 = 0; rvalid2 = 0; rresp2 = 0; rdata2 = 0;
        if (rst || gen != s2_gen) begin
            s2_gen = gen;
            awready2 = 0; wready2 = 0; bvalid2 = 0; bresp2 = 0;
            n_aw2 = 0; n_w2 = 0; saw_ar2 = 0; got_aw2 = 0; got_w2 = 0;
        end else begin
            if (p2_awv && awready2 && n_aw2 < 16) begin
                aw2_log[n_aw2] = p2_awaddr; n_aw2++; got_aw2 = 1;
            end
            if (p2_wv && wready2 && n_w2 < 16) begin
                w2_log[n_w2] = p2_wdata; n_w2++; got_w2 = 1;
            end
            if (bvalid2 && p2_bready) bvalid2 = 0;
            if (got_aw2 && got_w2 && !bvalid2) begin
                bvalid2 = 1; bresp2 = 2'b10; got_aw2 = 0; got_w2 = 0;
            end
            if (arvalid2) saw_ar2 = 1;
            awready2 = 1; wready2 = 1;
        end
        p2_awv = awvalid2; p2_wv = wvalid2; p2_bready = bready2;
        p2_awaddr = awaddr2; p2_wdata = wdata2;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge clk);
        gen = gen + 1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input bit chk_lat);
        @(negedge clk);
        init1 = 1;
        @(negedge clk);
        chk("start_clears", 64'({done1, error1, errcnt1, erraddr1}), 64'd0);
        if (chk_lat) chk("latency_p0_awvalid", 64'(awvalid1), 64'd0);
        @(negedge clk);
        init1 = 0;
        if (chk_lat) chk("latency_p1_awvalid", 64'({awvalid1, wvalid1}), 64'd3);
    endtask

    task automatic wait_done(input int which);
        for (int c = 0; c < 3000; c++) begin
            if ((which == 1) ? done1 : done2) break;
            @(negedge clk);
        end
        chk("done_reached", 64'((which == 1) ? done1 : done2), 64'd1);
    endtask

    typedef struct {
        string       name;
        bit          stall;
        bit [3:0]    corrupt;
        bit [3:0]    rresp;
        bit          bresp;
        bit          exp_err;
        logic [15:0] exp_cnt;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{"ideal",        0, 4'b0000, 4'b0000, 0, 0, 16'd0, 32'h0};
        vecs[1] = '{"stall",        1, 4'b0000, 4'b0000, 0, 0, 16'd0, 32'h0};
        vecs[2] = '{"corrupt_1_3",  0, 4'b1010, 4'b0000, 0, 1, 16'd2, 32'h4000_0004};
        vecs[3] = '{"bresp_all",    0, 4'b0000, 4'b0000, 1, 1, 16'd4, 32'h4000_0000};
        vecs[4] = '{"stall_c_2_3",  1, 4'b1100, 4'b0000, 0, 1, 16'd2, 32'h4000_0008};
        vecs[5] = '{"rresp_c_0",    0, 4'b0001, 4'b0001, 0, 1, 16'd1, 32'h4000_0000};
        vecs[6] = '{"stall_b_r3",   1, 4'b0000, 4'b1000, 1, 1, 16'd5, 32'h4000_0000};
        vecs[7] = '{"clean_after",  0, 4'b0000, 4'b0000, 0, 0, 16'd0, 32'h0};

        repeat (4) @(negedge clk);
        chk("rst_valids", 64'({awvalid1, wvalid1, bready1, arvalid1, rready1}), 64'd0);
        chk("rst_flags", 64'({done1, error1, errcnt1}), 64'd0);
        chk("rst_erraddr", 64'(erraddr1), 64'd0);
        chk("rst_addr_data", 64'({awaddr1, araddr1} | {32'd0, wdata1}), 64'd0);
        chk("rst_prot_strb", 64'({awprot1, arprot1, wstrb1}), 64'h00F);
        chk("rst_dut2", 64'({awvalid2, wvalid2, done2, errcnt2}), 64'd0);
        rst = 0;

        for (int k = 0; k < 8; k++) begin
            cfg_stall = vecs[k].stall;
            cfg_corrupt = vecs[k].corrupt;
            cfg_rresp = vecs[k].rresp;
            cfg_bresp = vecs[k].bresp;
            clear_logs();
            start_run(k == 0);
            wait_done(1);
            chk({vecs[k].name, "_error"}, 64'(error1), 64'(vecs[k].exp_err));
            chk({vecs[k].name, "_errcnt"}, 64'(errcnt1), 64'(vecs[k].exp_cnt));
            chk({vecs[k].name, "_erraddr"}, 64'(erraddr1), 64'(vecs[k].exp_addr));
            chk({vecs[k].name, "_counts"}, 64'({n_aw[7:0], n_w[7:0], n_ar[7:0]}), 64'h040404);
            chk({vecs[k].name, "_protocol"}, 64'(viol), 64'd0);
            chk({vecs[k].name, "_valids_done"},
                64'({awvalid1, wvalid1, arvalid1}), 64'd0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s_awaddr%0d", vecs[k].name, i),
                    64'(aw_log[i]), 64'(32'h4000_0000 + 32'(4 * i)));
                chk($sformatf("%s_wdata%0d", vecs[k].name, i),
                    64'(w_log[i]), 64'(32'hAA00_0000 + 32'(i)));
                chk($sformatf("%s_araddr%0d", vecs[k].name, i),
                    64'(ar_log[i]), 64'(32'h4000_0000 + 32'(4 * i)));
            end
            if (!vecs[k].stall) begin
                chk({vecs[k].name, "_wr_period"}, 64'(aw_cyc[1] - aw_cyc[0]), 64'd3);
                chk({vecs[k].name, "_rd_period"}, 64'(ar_cyc[1] - ar_cyc[0]), 64'd2);
            end
        end

        // reset while the third write is outstanding
        cfg_stall = 0; cfg_corrupt = 0; cfg_rresp = 0; cfg_bresp = 0;
        clear_logs();
        start_run(0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (n_aw == 2 && awvalid1) break;
        end
        chk("rstmid_third_write", 64'({n_aw[7:0], 7'd0, awvalid1}), 64'h0201);
        rst = 1;
        @(negedge clk);
        chk("rstmid_valids", 64'({awvalid1, wvalid1, bready1, arvalid1, rready1}), 64'd0);
        chk("rstmid_flags", 64'({done1, error1, errcnt1, awaddr1}), 64'd0);
        @(negedge clk);
        rst = 0;
        clear_logs();
        start_run(0);
        wait_done(1);
        chk("rstmid_rerun_first", 64'(aw_log[0]), 64'h4000_0000);
        chk("rstmid_rerun_result", 64'({error1, errcnt1, n_aw[7:0], n_ar[7:0]}), 64'h0_0000_0404);

        // second INIT edge mid-run is ignored
        clear_logs();
        start_run(0);
        repeat (6) @(negedge clk);
        init1 = 1;
        repeat (2) @(negedge clk);
        init1 = 0;
        wait_done(1);
        chk("midinit_counts", 64'({n_aw[7:0], n_w[7:0], n_ar[7:0]}), 64'h040404);
        chk("midinit_errcnt", 64'(errcnt1), 64'd0);

        // INIT held high starts one run only
        clear_logs();
        init1 = 1;
        @(negedge clk);
        @(negedge clk);
        wait_done(1);
        clear_logs();
        repeat (30) @(negedge clk);
        chk("held_done", 64'(done1), 64'd1);
        chk("held_no_retrigger", 64'({n_aw[7:0], n_ar[7:0]}), 64'd0);
        init1 = 0;

        // write-only, 64-bit, SLVERR on every write
        clear_logs();
        @(negedge clk);
        init2 = 1;
        repeat (2) @(negedge clk);
        init2 = 0;
        wait_done(2);
        chk("m1_errcnt", 64'(errcnt2), 64'd8);
        chk("m1_error", 64'(error2), 64'd1);
        chk("m1_erraddr", 64'(erraddr2), 64'h4000_0000);
        chk("m1_counts", 64'({n_aw2[7:0], n_w2[7:0]}), 64'h0808);
        chk("m1_no_ar", 64'(saw_ar2), 64'd0);
        chk("m1_wstrb", 64'(wstrb2), 64'hFF);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m1_awaddr%0d", i), 64'(aw2_log[i]), 64'(32'h4000_0000 + 32'(8 * i)));
            chk($sformatf("m1_wdata%0d", i), w2_log[i], 64'h0000_0000_AA00_0000 + 64'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
